mult_iter_ci: RTL and testbench
===============================

// Module: mult_iter_ci
// PURPOSE
//  Parametrised multi-cycle multiplier, the successor to the single-cycle LPM 32x32 multiplier.
//  Handshake follows the Nios II multi-cycle custom-instruction protocol (start/done).
//  Retires BITS_PER_CYC multiplier bits per clock, trading latency for area.
//  Adds signed/unsigned mode and low/high product-half select.
// PARAMETERS
//  WIDTH         32  operand and result width; full product is 2*WIDTH internally
//  BITS_PER_CYC   4  multiplier bits consumed per RUN cycle; must divide WIDTH (elaboration error otherwise)
// PORTS
//  clk      in   1      system clock, rising edge
//  reset_n  in   1      synchronous reset, active low
//  clk_en   in   1      clock enable; when 0 all state, including done, holds
//  start    in   1      request; sampled when clk_en=1 and FSM is IDLE
//  dataa    in   WIDTH  multiplicand, captured on the accepted start
//  datab    in   WIDTH  multiplier, captured on the accepted start
//  n        in   2      mode, captured with operands: n[0]=signed, n[1]=return high half
//  done     out  1      one-cycle pulse; result valid while done=1
//  result   out  WIDTH  selected product half; holds until the next done
//  busy     out  1      1 while the FSM is in RUN
//  ovf      out  1      saturation flag, valid with done (see CONFIGURATION)
// BEHAVIOUR
//  Reset: reset_n=0 at an edge forces IDLE; done=0, busy=0, result=0, ovf=0, internal regs=0.
//   Reset takes priority over clk_en, including mid-RUN; the operation in flight is discarded and produces no done.
//  All updates below require clk_en=1; with clk_en=0 nothing changes.
//  States:
//   - IDLE, start=1 -> capture operands and mode. If n[0]=1, store operand magnitudes and sign = a^b.
//     Clear acc(2*WIDTH) and cnt; go to RUN.
//   - RUN, each edge: acc += mcand * mplier[K-1:0] << (cnt*K), where K=BITS_PER_CYC. Then mplier >>= K; cnt++.
//   - RUN, edge with cnt == WIDTH/K-1: form the final product, negated if signed and sign=1.
//     Register result = n[1] ? prod[2W-1:W] : prod[W-1:0]; done<=1; go to IDLE.
//  Latency: done is high in the cycle that begins WIDTH/K enabled edges after the start-accept edge (8 at defaults).
//  done is high for exactly one enabled cycle. If clk_en=0 in that cycle, done stays high until the next enabled edge.
//  start while busy=1: ignored; no queueing.
//  start in the done=1 cycle: accepted (FSM is IDLE); gives back-to-back throughput of one op per WIDTH/K+1 cycles.
//  Signed mode: the full 2W-bit two's-complement product is exact; the magnitude path is W-bit unsigned.
//   -2^(W-1) * -2^(W-1) = 2^(2W-2) is handled correctly.
//  Unsigned mode: the product is exact in 2W bits; the low half wraps modulo 2^W.
// CONFIGURATION
//  MULT_ITER_SATURATE_EN defined:
//   - Applies only when n[1]=0 (low half).
//   - If the 2W product does not fit the W-bit range, result clamps and ovf=1 with done.
//     Unsigned range: [0, 2^W-1]. Signed range: [-2^(W-1), 2^(W-1)-1].
//   - Clamp value: unsigned -> all ones; signed positive -> 0x7F..F; signed negative -> 0x80..0.
//   - n[1]=1 never saturates; ovf=0.
//  MULT_ITER_SATURATE_EN undefined: the low half truncates (wraps); ovf is tied to 0. No saturation logic is synthesised.
// TESTING (WIDTH=32, BITS_PER_CYC=4, clk_en=1 unless stated)
//  1. a=332, b=22, n=00 -> result=7304 (0x1C88), done 8 cycles after start edge, ovf=0, busy high 8 cycles.
//  2. a=0xFFFFFFFD (-3), b=7, n=01 -> result=0xFFFFFFEB (-21); same a,b with n=00 -> 0xFFFFFFEB (low half identical).
//  3. a=b=0xFFFFFFFF, n=10 -> 0xFFFFFFFE; n=11 -> 0x00000000; n=00 -> 0x00000001 (ovf=1 and 0xFFFFFFFF if _EN).
//  4. a=b=0x00010000, n=00: no macro -> 0x00000000, ovf=0; MULT_ITER_SATURATE_EN -> 0xFFFFFFFF, ovf=1.
//     a=0x40000000, b=2, n=01 with macro -> 0x7FFFFFFF, ovf=1.
//  5. a=1,b=2: clk_en=0 for 3 cycles mid-RUN -> done at cycle 11, result=2.
//     Restart, reset_n=0 at RUN cycle 4 -> no done, busy=0, result=0; then a=2,b=23 -> 46.
//  6. start held high continuously with a=2,b=23 -> second start during busy ignored.
//     Start in the done cycle is accepted: done pulses every 9 cycles, result=46 each time.

Source files
------------

// File: rtl/mult_iter_ci.sv
// mult_iter_ci: iterative signed/unsigned multiplier with start/done handshake, BITS_PER_CYC bits per cycle
// Optional clamp of the low half on overflow is built only when MULT_ITER_SATURATE_EN is defined.
module mult_iter_ci #(
  parameter int WIDTH        = 32,
  parameter int BITS_PER_CYC = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic [1:0]       n,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             ovf
);
  localparam int K     = BITS_PER_CYC;
  localparam int STEPS = WIDTH / K;
  localparam int CW    = STEPS > 1 ? $clog2(STEPS) : 1;
  localparam int PW    = 2 * WIDTH;
  if (WIDTH % BITS_PER_CYC != 0) begin : g_bad_cfg
    $error("mult_iter_ci: BITS_PER_CYC must divide WIDTH");
  end
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state;
  logic [WIDTH-1:0] mcand, mplier, res_nx;
  logic [PW-1:0]    acc, part, acc_nx, prod;
  logic [CW-1:0]    cnt;
  logic             sgn, sgd, hi_sel, ovf_nx;
  // Operands are held as magnitudes; the sign is reapplied to the full product at the end.
  always_comb begin
    part   = (PW'(mcand) * PW'(mplier[K-1:0])) << (cnt * K);
    acc_nx = acc + part;
    prod   = sgn ? -acc_nx : acc_nx;
  end
`ifdef MULT_ITER_SATURATE_EN
  logic             fits;
  logic [WIDTH-1:0] clamp;
  always_comb begin
    fits   = sgd ? (&prod[PW-1:WIDTH-1] | ~|prod[PW-1:WIDTH-1]) : ~|prod[PW-1:WIDTH];
    clamp  = sgd ? (prod[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : '1;
    ovf_nx = ~hi_sel & ~fits;
    res_nx = hi_sel ? prod[PW-1:WIDTH] : ovf_nx ? clamp : prod[WIDTH-1:0];
  end
`else
  always_comb begin
    ovf_nx = 1'b0;
    res_nx = hi_sel ? prod[PW-1:WIDTH] : prod[WIDTH-1:0];
  end
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      done   <= 1'b0;
      busy   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      sgd    <= 1'b0;
      hi_sel <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          mcand  <= (n[0] & dataa[WIDTH-1]) ? -dataa : dataa;
          mplier <= (n[0] & datab[WIDTH-1]) ? -datab : datab;
          sgn    <= n[0] & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
          sgd    <= n[0];
          hi_sel <= n[1];
          acc    <= '0;
          cnt    <= '0;
          busy   <= 1'b1;
          state  <= RUN;
        end
      end else begin
        acc    <= acc_nx;
        mplier <= mplier >> K;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(STEPS - 1)) begin
          result <= res_nx;
          ovf    <= ovf_nx;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_mult_iter_ci.sv
// tb_mult_iter_ci: directed table vectors plus stall, reset and back-to-back sequences
module tb_mult_iter_ci;
  logic        clk = 0, reset_n = 0, clk_en = 1, start = 0;
  logic [31:0] dataa = 0, datab = 0, result;
  logic [1:0]  n = 0;
  logic        done, busy, ovf;
  int          checks = 0, errors = 0;
  mult_iter_ci #(.WIDTH(32), .BITS_PER_CYC(4)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .n(n),
    .done(done), .result(result), .busy(busy), .ovf(ovf)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  m;
    logic [31:0] r;
    logic        o;
  } vec_t;
  vec_t v[15];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run_op(input logic [31:0] a, b, input logic [1:0] m,
                        output logic [31:0] r, output logic o, output int lat, output logic bz);
    @(negedge clk);
    dataa = a; datab = b; n = m; start = 1;
    @(negedge clk);
    start = 0;
    bz = busy;
    lat = 99; r = 'x; o = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k; r = result; o = ovf;
        break;
      end
    end
  endtask
  initial begin
    logic [31:0] r;
    logic        o, bz;
    int          lat, nd, last;
    logic        sat;
`ifdef MULT_ITER_SATURATE_EN
    sat = 1;
`else
    sat = 0;
`endif
    v[0]  = '{32'd332,      32'd22,       2'b00, 32'd7304,     1'b0};
    v[1]  = '{32'hFFFFFFFD, 32'd7,        2'b01, 32'hFFFFFFEB, 1'b0};
    v[2]  = '{32'hFFFFFFFD, 32'd7,        2'b00, sat ? 32'hFFFFFFFF : 32'hFFFFFFEB, sat};
    v[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFE, 1'b0};
    v[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'h00000000, 1'b0};
    v[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, sat ? 32'hFFFFFFFF : 32'h00000001, sat};
    v[6]  = '{32'h00010000, 32'h00010000, 2'b00, sat ? 32'hFFFFFFFF : 32'h00000000, sat};
    v[7]  = '{32'h40000000, 32'd2,        2'b01, sat ? 32'h7FFFFFFF : 32'h80000000, sat};
    v[8]  = '{32'h80000000, 32'h80000000, 2'b01, sat ? 32'h7FFFFFFF : 32'h00000000, sat};
    v[9]  = '{32'h80000000, 32'h80000000, 2'b11, 32'h40000000, 1'b0};
    v[10] = '{32'h80000000, 32'd2,        2'b01, sat ? 32'h80000000 : 32'h00000000, sat};
    v[11] = '{32'h80000000, 32'd2,        2'b11, 32'hFFFFFFFF, 1'b0};
    v[12] = '{32'h12345678, 32'd0,        2'b00, 32'h00000000, 1'b0};
    v[13] = '{32'hFFFFFFFF, 32'd2,        2'b10, 32'h00000001, 1'b0};
    v[14] = '{32'd7,        32'hFFFFFFFB, 2'b01, 32'hFFFFFFDD, 1'b0};
    repeat (2) @(negedge clk);
    chk("reset_done", 32'(done), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_result", result, 0);
    chk("reset_ovf", 32'(ovf), 0);
    reset_n = 1;
    for (int i = 0; i < 15; i++) begin
      run_op(v[i].a, v[i].b, v[i].m, r, o, lat, bz);
      chk($sformatf("vec%0d_result", i), r, v[i].r);
      chk($sformatf("vec%0d_ovf", i), 32'(o), 32'(v[i].o));
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_busy", i), 32'(bz), 1);
    end
    // clk_en low for 3 cycles mid-run, then low again in the done cycle
    @(negedge clk);
    dataa = 1; datab = 2; n = 0; start = 1;
    @(negedge clk);
    start = 0;
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 3) clk_en = 0;
      if (k == 6) clk_en = 1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("stall_latency", lat, 11);
    chk("stall_result", result, 2);
    clk_en = 0;
    repeat (2) @(negedge clk);
    chk("stall_done_hold", 32'(done), 1);
    clk_en = 1;
    @(negedge clk);
    chk("stall_done_drop", 32'(done), 0);
    // reset in the middle of a run discards the operation
    @(negedge clk);
    dataa = 5; datab = 5; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", result, 0);
    reset_n = 1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rst_no_done", nd, 0);
    run_op(32'd2, 32'd23, 2'b00, r, o, lat, bz);
    chk("post_rst_result", r, 46);
    chk("post_rst_latency", lat, 8);
    // start held high: busy-time starts ignored, done-cycle start accepted
    @(negedge clk);
    dataa = 2; datab = 23; n = 0; start = 1;
    nd = 0; last = 0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        chk($sformatf("b2b_result%0d", nd), result, 46);
        chk($sformatf("b2b_time%0d", nd), t, nd * 9);
        last = t;
      end
    end
    start = 0;
    chk("b2b_count", nd, 4);
    chk("b2b_last", last, 36);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
